// File: rtl/gg_nal_slice_ctrl_pkg.sv
// Shared types for the NAL/slice sequencer: FSM state encoding and the
// slice record that is queued to the CABAC/MB scheduler.
package gg_nal_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SEEK,
    ST_SLICE,
    ST_ABORT
  } nal_ctrl_state_t;

  typedef struct packed {
    logic        abort;
    logic [31:0] start_off;
    logic [31:0] end_off;
    logic [31:0] len;
  } slice_rec_t;

  localparam int REC_W = $bits(slice_rec_t);

  // Builds a record; the length wraps modulo 2^32 like the offsets.
  function automatic slice_rec_t make_rec(input logic        abort,
                                          input logic [31:0] start_off,
                                          input logic [31:0] end_off);
    slice_rec_t r;
    r.abort     = abort;
    r.start_off = start_off;
    r.end_off   = end_off;
    r.len       = end_off - start_off;
    return r;
  endfunction

endpackage

// File: rtl/gg_nal_slice_ctrl_if.sv
// Lattice-side flags and the slice record valid/ready channel.
// master = sequencer side, slave = lattice/consumer side.
interface gg_nal_slice_ctrl_if #(
  parameter int WIDTH = 32
);
  import gg_nal_ctrl_pkg::*;

  localparam int BYTE_WIDTH = WIDTH / 8;

  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] nal_start;
  logic [BYTE_WIDTH-1:0] slice_start;
  logic [BYTE_WIDTH-1:0] slice_end;
  logic                  rec_valid;
  logic                  rec_ready;
  slice_rec_t            rec_data;

  modport master (
    input  in_valid, slice_start, slice_end, rec_ready,
    output nal_start, rec_valid, rec_data
  );

  modport slave (
    output in_valid, slice_start, slice_end, rec_ready,
    input  nal_start, rec_valid, rec_data
  );

endinterface

// File: rtl/gg_nal_slice_ctrl_rec_fifo.sv
// Synchronous first-word-fall-through FIFO for slice records. A push is
// accepted when not full, or when full and a pop happens in the same cycle.
module gg_slice_rec_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Record storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head-of-queue read, forced to zero while empty.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pop_data = '0;
    if (!empty) pop_data = mem[rd_ptr];
  end

endmodule

// File: rtl/gg_nal_slice_ctrl.sv
// NAL/slice sequencer: seeds the NAL lattice, tracks slice start/end byte
// flags, stamps slices with absolute byte offsets, aborts hung slices via a
// watchdog and queues slice records downstream.
// Optional feature macro: GG_NAL_SLICE_CTRL_STATS_EN (adds stat_slices/stat_aborts).
module gg_nal_slice_ctrl
  import gg_nal_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REC_DEPTH    = 4,
  parameter int MAX_SLC_WRDS = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       stop,
  gg_nal_slice_ctrl_if.master        bus,
  output logic                       busy,
  output logic [2:0]                 err_sticky
`ifdef GG_NAL_SLICE_CTRL_STATS_EN
  ,
  output logic [31:0]                stat_slices,
  output logic [15:0]                stat_aborts
`endif
);

  localparam int            BW        = WIDTH / 8;
  localparam int            IW        = (BW > 1) ? $clog2(BW) : 1;
  localparam int            WW        = (MAX_SLC_WRDS > 1) ? $clog2(MAX_SLC_WRDS) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(MAX_SLC_WRDS - 1);
  localparam logic [BW-1:0] SEED_FLAG = BW'(1) << (BW - 1);

  nal_ctrl_state_t state, state_nx;
  logic [29:0]     wcnt;
  logic [WW-1:0]   wdog;
  logic [31:0]     start_off;
  logic            stop_pend;

  logic            s_any, e_any, lo_any, hi_any, s_multi;
  logic [IW-1:0]   s_idx, e_idx, lo_idx;
  logic [31:0]     word_base, s_off, e_off, lo_off;

  logic            push, start_ld, wdog_clr, set_orphan, set_multi;
  logic [31:0]     start_new;
  slice_rec_t      push_rec;
  logic            fifo_full, fifo_empty, pop, overflow;
  logic            go_ok, stop_eff;

  assign busy      = (state != ST_IDLE);
  assign go_ok     = (state == ST_IDLE) && go;
  assign stop_eff  = stop_pend || stop;
  assign word_base = 32'(wcnt) * 32'(BW);
  assign s_off     = word_base + 32'(BW - 1) - 32'(s_idx);
  assign e_off     = word_base + 32'(BW - 1) - 32'(e_idx);
  assign lo_off    = word_base + 32'(BW - 1) - 32'(lo_idx);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Priority encoders: highest set bit is the earliest byte in the word.
  always_comb begin
    s_any   = |bus.slice_start;
    e_any   = |bus.slice_end;
    s_idx   = '0;
    e_idx   = '0;
    lo_any  = 1'b0;
    lo_idx  = '0;
    for (int i = 0; i < BW; i++) begin
      if (bus.slice_start[i]) s_idx = IW'(i);
      if (bus.slice_end[i])   e_idx = IW'(i);
    end
    // Earliest start that follows the end byte in the same word.
    for (int i = 0; i < BW; i++) begin
      if (bus.slice_start[i] && (IW'(i) < e_idx)) begin
        lo_any = 1'b1;
        lo_idx = IW'(i);
      end
    end
    hi_any  = s_any && (s_idx >= e_idx);
    s_multi = (bus.slice_start & (bus.slice_start - BW'(1))) != '0;
  end

  // Next-state, seeding, record push and error-flag decisions.
  always_comb begin
    state_nx      = state;
    bus.nal_start = '0;
    push          = 1'b0;
    push_rec      = '0;
    start_ld      = 1'b0;
    start_new     = s_off;
    wdog_clr      = 1'b0;
    set_orphan    = 1'b0;
    set_multi     = 1'b0;
    unique case (state)
      ST_IDLE: if (go) state_nx = ST_SEED;
      ST_SEED, ST_ABORT: begin
        if (bus.in_valid && !stop_eff) bus.nal_start = SEED_FLAG;
        if (stop_eff)          state_nx = ST_IDLE;
        else if (bus.in_valid) state_nx = ST_SEEK;
      end
      ST_SEEK: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (bus.in_valid) begin
          set_orphan = e_any;
          if (s_any) begin
            set_multi = s_multi;
            start_ld  = 1'b1;
            wdog_clr  = 1'b1;
            state_nx  = ST_SLICE;
          end
        end
      end
      ST_SLICE: begin
        if (bus.in_valid && e_any) begin
          push      = 1'b1;
          push_rec  = make_rec(1'b0, start_off, e_off);
          set_multi = hi_any;
          if (stop_eff) begin
            state_nx = ST_IDLE;
          end else if (lo_any) begin
            start_ld  = 1'b1;
            start_new = lo_off;
            wdog_clr  = 1'b1;
          end else begin
            state_nx = ST_SEEK;
          end
        end else if (bus.in_valid) begin
          set_multi = s_any;
          if (wdog == WDOG_LAST) begin
            push     = 1'b1;
            push_rec = make_rec(1'b1, start_off, word_base);
            state_nx = ST_ABORT;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Word counter, watchdog, slice start offset and pending stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt      <= '0;
      wdog      <= '0;
      start_off <= '0;
      stop_pend <= 1'b0;
    end else begin
      if (go_ok)                                wcnt <= '0;
      else if (busy && bus.in_valid)            wcnt <= wcnt + 30'd1;
      if (wdog_clr)                             wdog <= '0;
      else if (state == ST_SLICE && bus.in_valid) wdog <= wdog + WW'(1);
      if (start_ld)                             start_off <= start_new;
      if (state_nx == ST_IDLE)                  stop_pend <= 1'b0;
      else if (state == ST_SLICE && stop)       stop_pend <= 1'b1;
    end
  end

  // Sticky error flags {overflow, orphan_end, multi_start}.
  always_ff @(posedge clk) begin
    if (reset || go_ok) err_sticky <= '0;
    else                err_sticky <= err_sticky | {overflow, set_orphan, set_multi};
  end

  assign pop           = bus.rec_ready && !fifo_empty;
  assign overflow      = push && fifo_full && !pop;
  assign bus.rec_valid = !fifo_empty;

  gg_slice_rec_fifo #(
    .DEPTH (REC_DEPTH),
    .T     (slice_rec_t)
  ) u_rec_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (bus.rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef GG_NAL_SLICE_CTRL_STATS_EN
  // Saturating counts of pushed records and watchdog aborts.
  always_ff @(posedge clk) begin
    if (reset || go_ok) begin
      stat_slices <= '0;
      stat_aborts <= '0;
    end else if (push) begin
      if (stat_slices != '1)                    stat_slices <= stat_slices + 32'd1;
      if (push_rec.abort && stat_aborts != '1)  stat_aborts <= stat_aborts + 16'd1;
    end
  end
`endif

endmodule
